sar_search_ctrl: RTL

//  Successive-approximation search controller. It is the initiator side of the 4-bit

---
 rtl/sar_pkg.sv | 20 ++
 rtl/sar_settle_cnt.sv | 33 +++
 rtl/sar_search_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding, default parameter values and the comparator flag check.
package sar_pkg;

    localparam int SAR_WIDTH_DEFAULT  = 4;
    localparam int SAR_SETTLE_DEFAULT = 0;
    // Settle counter width; covers SETTLE values 0..15.
    localparam int SAR_CNT_W          = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } sar_state_t;

    // True when exactly one of {lt, eq, gt} is asserted.
    function automatic logic onehot3(input logic [2:0] flags);
        return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
    endfunction

endpackage

// File: rtl/sar_settle_cnt.sv
// Loadable down-counter that holds off comparator sampling after each trial
// update; stops at zero and flags when zero is reached.
module sar_settle_cnt
    import sar_pkg::*;
#(
    parameter int CNT_W = SAR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_zero
);

    logic [CNT_W-1:0] cnt_reg;

    // Load has priority over decrement; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign cnt      = cnt_reg;
    assign cnt_zero = (cnt_reg == '0);

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller. Drives a trial operand into an
// external magnitude comparator (a = target, b = trial), resolves the target
// one bit per step MSB first, and reports the result on a start/done handshake.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH  = SAR_WIDTH_DEFAULT,
    parameter int SETTLE = SAR_SETTLE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]     IDX_MSB   = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]     TRIAL_MSB = WIDTH'(1) << (WIDTH - 1);
    localparam logic [SAR_CNT_W-1:0] SETTLE_V  = SAR_CNT_W'(SETTLE);

    sar_state_t       state_reg,   state_next;
    logic [WIDTH-1:0] trial_reg,   trial_next;
    logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
    logic [WIDTH-1:0] result_reg,  result_next;
    logic             exact_reg,   exact_next;
    logic             err_reg,     err_next;
    logic             done_reg,    done_next;

    logic                 cnt_load;
    logic [SAR_CNT_W-1:0] cnt_load_val;
    logic                 cnt_dec;
    logic [SAR_CNT_W-1:0] cnt_val;
    logic                 cnt_zero;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] value;
    logic             flags_ok;

    genvar gi;

    // One-hot mask selecting the bit currently under test.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign bit_mask[gi] = (bit_idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Trial with the bit under test cleared when the target is below it.
    assign value    = cmp_lt ? (trial_reg & ~bit_mask) : trial_reg;
    assign flags_ok = onehot3({cmp_lt, cmp_eq, cmp_gt});

    sar_settle_cnt #(
        .CNT_W (SAR_CNT_W)
    ) u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .cnt_zero (cnt_zero)
    );

    // State, trial/bit index and result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            trial_reg   <= '0;
            bit_idx_reg <= IDX_MSB;
            result_reg  <= '0;
            exact_reg   <= 1'b0;
            err_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            trial_reg   <= trial_next;
            bit_idx_reg <= bit_idx_next;
            result_reg  <= result_next;
            exact_reg   <= exact_next;
            err_reg     <= err_next;
            done_reg    <= done_next;
        end
    end

    // Next-state logic: start acceptance, settle wait, one sample per bit,
    // abort taking priority over any sample in the same cycle.
    always_comb begin
        state_next   = state_reg;
        trial_next   = trial_reg;
        bit_idx_next = bit_idx_reg;
        result_next  = result_reg;
        exact_next   = exact_reg;
        err_next     = err_reg;
        done_next    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next   = SEARCH;
                    trial_next   = TRIAL_MSB;
                    bit_idx_next = IDX_MSB;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETTLE_V;
                    exact_next   = 1'b0;
                    err_next     = 1'b0;
                end
            end

            SEARCH: begin
                if (abort) begin
                    // Cancel quietly: no done, result keeps its last value.
                    state_next   = IDLE;
                    trial_next   = '0;
                    bit_idx_next = IDX_MSB;
                    cnt_load     = 1'b1;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (!flags_ok) begin
                    state_next   = IDLE;
                    trial_next   = '0;
                    bit_idx_next = IDX_MSB;
                    result_next  = '0;
                    exact_next   = 1'b0;
                    err_next     = 1'b1;
                    done_next    = 1'b1;
                end else if (cmp_eq) begin
                    state_next   = IDLE;
                    trial_next   = '0;
                    bit_idx_next = IDX_MSB;
                    result_next  = trial_reg;
                    exact_next   = 1'b1;
                    done_next    = 1'b1;
                end else if (bit_idx_reg == '0) begin
                    state_next   = IDLE;
                    trial_next   = '0;
                    bit_idx_next = IDX_MSB;
                    result_next  = value;
                    exact_next   = 1'b0;
                    done_next    = 1'b1;
                end else begin
                    trial_next   = value | (bit_mask >> 1);
                    bit_idx_next = bit_idx_reg - 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETTLE_V;
                end
            end

            default: begin
                state_next = IDLE;
                trial_next = '0;
            end
        endcase
    end

    assign trial  = trial_reg;
    assign busy   = (state_reg == SEARCH);
    assign done   = done_reg;
    assign result = result_reg;
    assign exact  = exact_reg;
    assign err    = err_reg;

endmodule
